// File: rtl/dct_engine_arbiter.sv
// Round-robin scheduler sharing one non-pipelined 8-point DCT engine between N_REQ requesters.
// Tracks the single in-flight operation, buffers its result and flags engine hangs.
module dct_engine_arbiter #(
    parameter int IN_WIDTH  = 8,
    parameter int OUT_WIDTH = 18,
    parameter int N_REQ     = 2,
    parameter int ID_W      = $clog2(N_REQ),
    parameter int TIMEOUT   = 8
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [N_REQ-1:0]            req_valid,
    output logic [N_REQ-1:0]            req_ready,
    input  logic [N_REQ*8*IN_WIDTH-1:0] req_x,
    output logic                        eng_valid_in,
    output logic [8*IN_WIDTH-1:0]       eng_x,
    input  logic                        eng_valid_out,
    input  logic [8*OUT_WIDTH-1:0]      eng_y,
    output logic                        rsp_valid,
    input  logic                        rsp_ready,
    output logic [ID_W-1:0]             rsp_id,
    output logic [8*OUT_WIDTH-1:0]      rsp_y,
    output logic                        busy,
    output logic                        err_timeout,
    output logic [7:0]                  err_count
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic {
        S_IDLE,
        S_WAIT
    } state_t;

    state_t                 state_q, state_d;
    logic [ID_W-1:0]        last_q, last_d;
    logic [ID_W-1:0]        owner_q, owner_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   rsp_valid_q, rsp_valid_d;
    logic [ID_W-1:0]        rsp_id_q, rsp_id_d;
    logic [8*OUT_WIDTH-1:0] rsp_y_q, rsp_y_d;
    logic                   err_to_q, err_to_d;
    logic [7:0]             err_cnt_q, err_cnt_d;

    logic [8*IN_WIDTH-1:0]  lane [N_REQ];
    logic [ID_W-1:0]        cand;
    logic                   any_req;
    logic                   err_inc;

    always_comb begin
        for (int unsigned i = 0; i < N_REQ; i++) begin
            lane[i] = req_x[i*8*IN_WIDTH +: 8*IN_WIDTH];
        end
    end

    // Rotating priority: first pending lane after the previous winner.
    always_comb begin
        int unsigned     idx;
        logic [ID_W-1:0] idx_w;
        cand    = last_q;
        any_req = 1'b0;
        idx     = 0;
        idx_w   = '0;
        for (int unsigned off = 1; off <= N_REQ; off++) begin
            idx = 32'(last_q) + off;
            if (idx >= N_REQ) begin
                idx = idx - N_REQ;
            end
            idx_w = ID_W'(idx);
            if (!any_req && req_valid[idx_w]) begin
                any_req = 1'b1;
                cand    = idx_w;
            end
        end
    end

    assign eng_x = any_req ? lane[cand] : '0;

    always_comb begin
        state_d      = state_q;
        last_d       = last_q;
        owner_d      = owner_q;
        cnt_d        = cnt_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_id_d     = rsp_id_q;
        rsp_y_d      = rsp_y_q;
        err_to_d     = 1'b0;
        err_cnt_d    = err_cnt_q;
        err_inc      = 1'b0;
        req_ready    = '0;
        eng_valid_in = 1'b0;

        if (rsp_valid_q && rsp_ready) begin
            rsp_valid_d = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                if (eng_valid_out) begin
                    err_inc = 1'b1;
                end
                if (any_req && (!rsp_valid_q || rsp_ready)) begin
                    req_ready[cand] = 1'b1;
                    eng_valid_in    = 1'b1;
                    owner_d         = cand;
                    last_d          = cand;
                    cnt_d           = '0;
                    state_d         = S_WAIT;
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q + 1'b1;
                if (eng_valid_out) begin
                    rsp_y_d     = eng_y;
                    rsp_id_d    = owner_q;
                    rsp_valid_d = 1'b1;
                    state_d     = S_IDLE;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    err_to_d = 1'b1;
                    err_inc  = 1'b1;
                    state_d  = S_IDLE;
                end
            end
        endcase

        if (err_inc && (err_cnt_q != 8'hFF)) begin
            err_cnt_d = err_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            last_q      <= ID_W'(N_REQ - 1);
            owner_q     <= '0;
            cnt_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_y_q     <= '0;
            err_to_q    <= 1'b0;
            err_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            owner_q     <= owner_d;
            cnt_q       <= cnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_y_q     <= rsp_y_d;
            err_to_q    <= err_to_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign rsp_valid   = rsp_valid_q;
    assign rsp_id      = rsp_id_q;
    assign rsp_y       = rsp_y_q;
    assign busy        = (state_q == S_WAIT);
    assign err_timeout = err_to_q;
    assign err_count   = err_cnt_q;

endmodule

// File: tb/tb_dct_engine_arbiter.sv
// Directed bench for dct_engine_arbiter with a 5-cycle engine stub and a response scoreboard.
// Inputs change just after the falling edge; checks run 1 time unit later.
module tb_dct_engine_arbiter;

    localparam int IW  = 8;
    localparam int OW  = 18;
    localparam int NR  = 2;
    localparam int IDW = 1;
    localparam int TO  = 8;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [NR-1:0]        req_valid;
    logic [NR-1:0]        req_ready;
    logic [NR*8*IW-1:0]   req_x;
    logic                 eng_valid_in;
    logic [8*IW-1:0]      eng_x;
    logic                 eng_valid_out;
    logic [8*OW-1:0]      eng_y;
    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [IDW-1:0]       rsp_id;
    logic [8*OW-1:0]      rsp_y;
    logic                 busy;
    logic                 err_timeout;
    logic [7:0]           err_count;

    typedef struct packed {
        logic [IDW-1:0]  id;
        logic [8*OW-1:0] y;
    } exp_t;

    exp_t sbq[$];
    int   checks   = 0;
    int   failures = 0;

    logic            stub_en;
    logic            inj;
    logic [8*OW-1:0] inj_y;
    logic [2:0]      stub_cnt;
    logic [8*IW-1:0] stub_x;
    logic [8*OW-1:0] e512;
    logic [8*OW-1:0] bp_y;

    always #5 clk = ~clk;

    dct_engine_arbiter #(
        .IN_WIDTH (IW),
        .OUT_WIDTH(OW),
        .N_REQ    (NR),
        .ID_W     (IDW),
        .TIMEOUT  (TO)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_x        (req_x),
        .eng_valid_in (eng_valid_in),
        .eng_x        (eng_x),
        .eng_valid_out(eng_valid_out),
        .eng_y        (eng_y),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_id       (rsp_id),
        .rsp_y        (rsp_y),
        .busy         (busy),
        .err_timeout  (err_timeout),
        .err_count    (err_count)
    );

    // Stand-in transform: DC = 64*sum, AC[k] = 64*(x[k]-x[0]); all-ones gives 512 then zeros.
    function automatic logic [8*OW-1:0] eng_model(input logic [8*IW-1:0] x);
        logic [8*OW-1:0]   y;
        logic signed [IW-1:0] v;
        int s, x0, xk;
        y  = '0;
        s  = 0;
        v  = x[IW-1:0];
        x0 = int'(v);
        for (int k = 0; k < 8; k++) begin
            v  = x[k*IW +: IW];
            xk = int'(v);
            s  = s + xk;
            if (k > 0) y[k*OW +: OW] = OW'(64 * (xk - x0));
        end
        y[OW-1:0] = OW'(64 * s);
        return y;
    endfunction

    function automatic logic [8*IW-1:0] mk_lane(input int base, input int step);
        logic [8*IW-1:0] v;
        v = '0;
        for (int k = 0; k < 8; k++) v[k*IW +: IW] = IW'(base + step * k);
        return v;
    endfunction

    function automatic logic [8*OW-1:0] fill7();
        logic [8*OW-1:0] v;
        v = '0;
        for (int k = 0; k < 8; k++) v[k*OW +: OW] = OW'(7);
        return v;
    endfunction

    function automatic logic [8*IW-1:0] get_lane(input int i);
        return req_x[i*8*IW +: 8*IW];
    endfunction

    task automatic set_lane(input int i, input logic [8*IW-1:0] v);
        req_x[i*8*IW +: 8*IW] = v;
    endtask

    task automatic push_exp(input int id, input logic [8*OW-1:0] y);
        exp_t e;
        e.id = IDW'(id);
        e.y  = y;
        sbq.push_back(e);
    endtask

    task automatic chk(input string tag, input logic [143:0] got, input logic [143:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic chk_all_zero(input string pfx);
        chk({pfx, "_req_ready"}, 144'(req_ready), 144'(0));
        chk({pfx, "_eng_valid_in"}, 144'(eng_valid_in), 144'(0));
        chk({pfx, "_eng_x"}, 144'(eng_x), 144'(0));
        chk({pfx, "_rsp_valid"}, 144'(rsp_valid), 144'(0));
        chk({pfx, "_rsp_id"}, 144'(rsp_id), 144'(0));
        chk({pfx, "_rsp_y"}, 144'(rsp_y), 144'(0));
        chk({pfx, "_busy"}, 144'(busy), 144'(0));
        chk({pfx, "_err_timeout"}, 144'(err_timeout), 144'(0));
        chk({pfx, "_err_count"}, 144'(err_count), 144'(0));
    endtask

    task automatic reset_dut();
        @(negedge clk);
        rst_n     = 1'b0;
        req_valid = '0;
        inj       = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stub_cnt <= '0;
            stub_x   <= '0;
        end else if (eng_valid_in && stub_en) begin
            stub_cnt <= 3'd5;
            stub_x   <= eng_x;
        end else if (stub_cnt != 3'd0) begin
            stub_cnt <= stub_cnt - 3'd1;
        end
    end

    assign eng_valid_out = (stub_cnt == 3'd1) | inj;
    assign eng_y         = inj ? inj_y : eng_model(stub_x);

    // Scoreboard: every accepted response must match the oldest pending expectation.
    always begin
        exp_t e;
        @(negedge clk);
        #2;
        if (rst_n && rsp_valid && rsp_ready) begin
            chk("sb_pending", 144'(sbq.size() != 0), 144'(1));
            if (sbq.size() != 0) begin
                e = sbq.pop_front();
                chk("sb_rsp_id", 144'(rsp_id), 144'(e.id));
                chk("sb_rsp_y", 144'(rsp_y), 144'(e.y));
            end
        end
    end

    initial begin
        req_valid = '0;
        req_x     = '0;
        rsp_ready = 1'b0;
        stub_en   = 1'b1;
        inj       = 1'b0;
        inj_y     = '0;
        rst_n     = 1'b0;
        e512      = '0;
        e512[OW-1:0] = OW'(512);
        bp_y      = '0;

        repeat (2) @(negedge clk);
        #1;
        chk_all_zero("rst");
        @(negedge clk);
        rst_n = 1'b1;

        // Single request, lane 0, all ones
        @(negedge clk);
        set_lane(0, mk_lane(1, 0));
        req_valid = 2'b01;
        rsp_ready = 1'b1;
        push_exp(0, eng_model(get_lane(0)));
        #1;
        chk("t1_req_ready", 144'(req_ready), 144'(2'b01));
        chk("t1_eng_valid_in", 144'(eng_valid_in), 144'(1));
        chk("t1_eng_x", 144'(eng_x), 144'(mk_lane(1, 0)));
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            req_valid = '0;
            #1;
            chk("t1_busy", 144'(busy), 144'(1));
        end
        @(negedge clk);
        #1;
        chk("t1_rsp_valid", 144'(rsp_valid), 144'(1));
        chk("t1_rsp_id", 144'(rsp_id), 144'(0));
        chk("t1_rsp_y", 144'(rsp_y), 144'(e512));
        chk("t1_busy_done", 144'(busy), 144'(0));

        // Spurious engine strobe in IDLE
        @(negedge clk);
        inj   = 1'b1;
        inj_y = fill7();
        @(negedge clk);
        inj = 1'b0;
        #1;
        chk("sp_rsp_valid", 144'(rsp_valid), 144'(0));
        chk("sp_rsp_y", 144'(rsp_y), 144'(e512));
        chk("sp_err_count", 144'(err_count), 144'(1));

        // Both lanes requesting continuously
        reset_dut();
        rsp_ready = 1'b1;
        set_lane(0, mk_lane(3, 1));
        set_lane(1, mk_lane(-5, 2));
        for (int g = 0; g < 4; g++) begin
            @(negedge clk);
            if (g == 0) req_valid = 2'b11;
            #1;
            chk("rr_grant", 144'(req_ready), 144'(1 << (g % 2)));
            if (g > 0) begin
                chk("rr_rsp_valid", 144'(rsp_valid), 144'(1));
                chk("rr_rsp_id", 144'(rsp_id), 144'((g - 1) % 2));
            end
            push_exp(g % 2, eng_model(get_lane(g % 2)));
            for (int c = 1; c <= 5; c++) begin
                @(negedge clk);
                if (c == 1) begin
                    set_lane(g % 2, mk_lane(10 * g + 1, 3));
                    if (g == 3) req_valid = '0;
                end
                #1;
                chk("rr_wait_ready", 144'(req_ready), 144'(0));
            end
        end
        @(negedge clk);
        #1;
        chk("rr_last_valid", 144'(rsp_valid), 144'(1));
        chk("rr_last_id", 144'(rsp_id), 144'(1));

        // Response backpressure
        reset_dut();
        rsp_ready = 1'b0;
        @(negedge clk);
        set_lane(0, mk_lane(-20, 5));
        set_lane(1, mk_lane(7, -2));
        req_valid = 2'b01;
        bp_y = eng_model(get_lane(0));
        push_exp(0, bp_y);
        #1;
        chk("bp_grant0", 144'(req_ready), 144'(2'b01));
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            if (c == 1) req_valid = 2'b11;
            #1;
            chk("bp_wait_ready", 144'(req_ready), 144'(0));
        end
        for (int c = 6; c <= 25; c++) begin
            @(negedge clk);
            #1;
            chk("bp_hold_valid", 144'(rsp_valid), 144'(1));
            chk("bp_hold_ready", 144'(req_ready), 144'(0));
            chk("bp_hold_id", 144'(rsp_id), 144'(0));
            chk("bp_hold_y", 144'(rsp_y), 144'(bp_y));
            if (c == 6) chk("bp_engx_cand", 144'(eng_x), 144'(mk_lane(7, -2)));
        end
        @(negedge clk);
        rsp_ready = 1'b1;
        push_exp(1, eng_model(get_lane(1)));
        #1;
        chk("bp_release_ready", 144'(req_ready), 144'(2'b10));
        chk("bp_release_issue", 144'(eng_valid_in), 144'(1));
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            if (c == 1) req_valid = '0;
        end
        @(negedge clk);
        #1;
        chk("bp_rsp1_valid", 144'(rsp_valid), 144'(1));
        chk("bp_rsp1_id", 144'(rsp_id), 144'(1));

        // Watchdog: engine never answers
        reset_dut();
        rsp_ready = 1'b1;
        stub_en   = 1'b0;
        @(negedge clk);
        set_lane(0, mk_lane(2, 1));
        req_valid = 2'b01;
        #1;
        chk("to_grant", 144'(req_ready), 144'(2'b01));
        for (int c = 1; c <= TO; c++) begin
            @(negedge clk);
            if (c == 1) req_valid = '0;
            #1;
            chk("to_quiet", 144'(err_timeout), 144'(0));
            chk("to_norsp", 144'(rsp_valid), 144'(0));
        end
        @(negedge clk);
        set_lane(1, mk_lane(-3, 2));
        req_valid = 2'b10;
        stub_en   = 1'b1;
        push_exp(1, eng_model(get_lane(1)));
        #1;
        chk("to_pulse", 144'(err_timeout), 144'(1));
        chk("to_count", 144'(err_count), 144'(1));
        chk("to_rsp_valid", 144'(rsp_valid), 144'(0));
        chk("to_accept", 144'(req_ready), 144'(2'b10));
        @(negedge clk);
        req_valid = '0;
        #1;
        chk("to_pulse_end", 144'(err_timeout), 144'(0));
        repeat (4) @(negedge clk);
        @(negedge clk);
        #1;
        chk("to_next_valid", 144'(rsp_valid), 144'(1));
        chk("to_next_id", 144'(rsp_id), 144'(1));
        chk("to_count_hold", 144'(err_count), 144'(1));

        // Reset with an operation in flight
        reset_dut();
        rsp_ready = 1'b1;
        @(negedge clk);
        set_lane(0, mk_lane(9, 9));
        req_valid = 2'b01;
        #1;
        chk("mr_grant", 144'(req_ready), 144'(2'b01));
        @(negedge clk);
        req_valid = '0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk_all_zero("mr");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        inj   = 1'b1;
        inj_y = fill7();
        @(negedge clk);
        inj = 1'b0;
        repeat (6) @(negedge clk);
        #1;
        chk("mr_norsp", 144'(rsp_valid), 144'(0));
        chk("mr_rsp_y", 144'(rsp_y), 144'(0));
        chk("mr_err_count", 144'(err_count), 144'(1));

        // err_count saturation
        @(negedge clk);
        inj = 1'b1;
        repeat (300) @(negedge clk);
        inj = 1'b0;
        #1;
        chk("sat_err_count", 144'(err_count), 144'(255));
        chk("sat_rsp_valid", 144'(rsp_valid), 144'(0));

        repeat (2) @(negedge clk);
        chk("sb_drained", 144'(sbq.size()), 144'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
